mem_access_ctrl: RTL and testbench

- Owns the single-ported 256 x 32 data/instruction memory and shares it between the instruction-fetch port (IF) and the load/store data port (D).
- Grants at most one access per cycle and drives the memory's address, data, wr, rd and rst strobes.
- Registers read data back to the winning requester.
- Provides a hardware clear sequencer that zeroes the whole array on command.

---
 rtl/mem_ctrl_pkg.sv | 20 ++
 rtl/mem_arb_pick.sv | 38 +++
 rtl/mem_access_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types and default sizes for the memory access controller.
package mem_ctrl_pkg;

  localparam int unsigned ADDR_W_DEF     = 28;
  localparam int unsigned DATA_W_DEF     = 32;
  localparam int unsigned DEPTH_DEF      = 256;
  localparam int unsigned STARVE_MAX_DEF = 4;

  typedef enum logic {
    RUN,
    CLEAR
  } state_t;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_IF,
    SEL_D
  } sel_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational IF/D arbiter.
//   if_req, d_req : pending requests
//   starve_cnt    : contended IF losses so far (D-priority build)
//   last_d        : 1 when D was granted last (MEM_ARB_RR_EN build)
//   sel           : winning port
// MEM_ARB_RR_EN selects strict round-robin instead of D priority.
module mem_arb_pick
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned SW         = 3,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic          if_req,
  input  logic          d_req,
`ifdef MEM_ARB_RR_EN
  input  logic          last_d,
`else
  input  logic [SW-1:0] starve_cnt,
`endif
  output sel_t          sel
);

  always_comb begin
    sel = SEL_NONE;
    if (if_req && d_req) begin
`ifdef MEM_ARB_RR_EN
      sel = last_d ? SEL_IF : SEL_D;
`else
      sel = (starve_cnt == SW'(STARVE_MAX)) ? SEL_IF : SEL_D;
`endif
    end else if (if_req) begin
      sel = SEL_IF;
    end else if (d_req) begin
      sel = SEL_D;
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Shares a single-ported memory between instruction fetch (IF) and the
// load/store port (D), and sweeps the array to zero on clr_req.
//   clr_req/clr_busy              : clear command / sweep in progress
//   if_req/if_addr/if_gnt/...     : IF read port, registered response
//   d_req/d_we/d_addr/d_wdata/... : D load/store port, registered response
//   d_err                         : out-of-range D access, response slot
//   mem_*                         : memory strobes, mem_data1 read data
// MEM_ARB_RR_EN selects round-robin arbitration instead of D priority
// with IF starvation guard.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned DEPTH      = DEPTH_DEF,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_req,
  output logic              clr_busy,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wr,
  output logic              mem_rd,
  output logic              mem_rst,
  input  logic [DATA_W-1:0] mem_data1
);

  localparam int unsigned       CW      = $clog2(DEPTH);
  localparam int unsigned       SW      = $clog2(STARVE_MAX + 1);
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

  state_t          state;
  logic [CW-1:0]   clr_cnt;
  sel_t            pick;
  sel_t            sel;
  logic            run_ok;
  logic            if_oor;
  logic            d_oor;

  assign if_oor = (if_addr >= DEPTH_A);
  assign d_oor  = (d_addr >= DEPTH_A);

  // No grant in the clr_req cycle, during the sweep, or while in reset.
  assign run_ok   = (state == RUN) && !clr_req && !rst;
  assign sel      = run_ok ? pick : SEL_NONE;
  assign if_gnt   = (sel == SEL_IF);
  assign d_gnt    = (sel == SEL_D);
  assign clr_busy = (state == CLEAR);

`ifdef MEM_ARB_RR_EN
  logic last_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_d <= 1'b0;
    end else if (sel == SEL_IF) begin
      last_d <= 1'b0;
    end else if (sel == SEL_D) begin
      last_d <= 1'b1;
    end
  end

  mem_arb_pick #(.SW(SW), .STARVE_MAX(STARVE_MAX)) u_arb (
    .if_req (if_req),
    .d_req  (d_req),
    .last_d (last_d),
    .sel    (pick)
  );
`else
  logic [SW-1:0] starve_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (sel == SEL_IF) begin
      starve_cnt <= '0;
    end else if (sel == SEL_D && if_req) begin
      starve_cnt <= starve_cnt + SW'(1);
    end
  end

  mem_arb_pick #(.SW(SW), .STARVE_MAX(STARVE_MAX)) u_arb (
    .if_req     (if_req),
    .d_req      (d_req),
    .starve_cnt (starve_cnt),
    .sel        (pick)
  );
`endif

  always_comb begin
    mem_address = '0;
    mem_data    = '0;
    mem_wr      = 1'b0;
    mem_rd      = 1'b0;
    mem_rst     = 1'b0;
    if (!rst) begin
      if (state == CLEAR) begin
        mem_rst     = 1'b1;
        mem_address = ADDR_W'(clr_cnt);
      end else begin
        case (sel)
          SEL_IF: begin
            mem_address = if_addr;
            mem_rd      = !if_oor;
          end
          SEL_D: begin
            mem_address = d_addr;
            if (d_we) begin
              mem_data = d_wdata;
            end
            if (!d_oor) begin
              mem_wr = d_we;
              mem_rd = !d_we;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RUN;
      clr_cnt <= '0;
    end else begin
      case (state)
        RUN: begin
          if (clr_req) begin
            state <= CLEAR;
          end
        end
        CLEAR: begin
          if (clr_cnt == CW'(DEPTH - 1)) begin
            state   <= RUN;
            clr_cnt <= '0;
          end else begin
            clr_cnt <= clr_cnt + CW'(1);
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_rvalid <= 1'b0;
      if_rdata  <= '0;
      d_rvalid  <= 1'b0;
      d_rdata   <= '0;
      d_err     <= 1'b0;
    end else begin
      if_rvalid <= (sel == SEL_IF);
      if (sel == SEL_IF) begin
        if_rdata <= if_oor ? '0 : mem_data1;
      end
      d_rvalid <= (sel == SEL_D) && !d_we;
      if (sel == SEL_D && !d_we) begin
        d_rdata <= d_oor ? '0 : mem_data1;
      end
      d_err <= (sel == SEL_D) && d_oor;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

  localparam int unsigned AW    = 28;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 256;
  localparam int unsigned SMAX  = 4;

  logic          clk     = 1'b0;
  logic          rst     = 1'b1;
  logic          clr_req = 1'b0;
  logic          if_req  = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          d_req   = 1'b0;
  logic          d_we    = 1'b0;
  logic [AW-1:0] d_addr  = '0;
  logic [DW-1:0] d_wdata = '0;

  logic          clr_busy, if_gnt, if_rvalid, d_gnt, d_rvalid, d_err;
  logic [DW-1:0] if_rdata, d_rdata, mem_data, mem_data1;
  logic [AW-1:0] mem_address;
  logic          mem_wr, mem_rd, mem_rst;

  mem_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst), .clr_req(clr_req), .clr_busy(clr_busy),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_address(mem_address), .mem_data(mem_data), .mem_wr(mem_wr),
    .mem_rd(mem_rd), .mem_rst(mem_rst), .mem_data1(mem_data1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] seed_word(input int unsigned i);
    return (32'h9E37_79B9 * i) ^ 32'h5A5A_0000;
  endfunction

  function automatic bit inr(input logic [AW-1:0] a);
    return a < 28'd256;
  endfunction

  // Memory array attached to the controller's memory port.
  logic [DW-1:0] sim_mem [DEPTH];
  bit            sim_seeded = 1'b0;
  assign mem_data1 = inr(mem_address) ? sim_mem[mem_address[7:0]] : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    if (!sim_seeded) begin
      for (int i = 0; i < 256; i++) sim_mem[i] <= seed_word(i);
      sim_seeded <= 1'b1;
    end else begin
      if (mem_wr && inr(mem_address)) sim_mem[mem_address[7:0]] <= mem_data;
      if (mem_rst && inr(mem_address)) sim_mem[mem_address[7:0]] <= '0;
    end
  end

  // Reference model: contents, sweep progress, arbitration history, responses.
  logic [DW-1:0] ref_mem [DEPTH];
  bit            ref_seeded = 1'b0;
  bit            m_busy   = 1'b0;
  int unsigned   m_idx    = 0;
  int unsigned   m_losses = 0;
  bit            m_last_d = 1'b0;
  bit            p_if_v = 1'b0, p_d_v = 1'b0, p_d_err = 1'b0;
  logic [DW-1:0] h_if = '0, h_d = '0;
  bit            e_if_g = 1'b0, e_d_g = 1'b0, e_rd = 1'b0, e_wr = 1'b0;

  always @(negedge clk) begin
    e_if_g = 1'b0;
    e_d_g  = 1'b0;
    if (!m_busy && !clr_req) begin
      if (if_req && d_req) begin
`ifdef MEM_ARB_RR_EN
        if (m_last_d) e_if_g = 1'b1; else e_d_g = 1'b1;
`else
        if (m_losses >= SMAX) e_if_g = 1'b1; else e_d_g = 1'b1;
`endif
      end else begin
        e_if_g = if_req;
        e_d_g  = d_req;
      end
    end
    e_rd = (e_if_g && inr(if_addr)) || (e_d_g && !d_we && inr(d_addr));
    e_wr = e_d_g && d_we && inr(d_addr);
    if (!rst) begin
      chk("if_gnt", if_gnt, e_if_g);
      chk("d_gnt", d_gnt, e_d_g);
      chk("clr_busy", clr_busy, m_busy);
      chk("mem_rst", mem_rst, m_busy);
      chk("mem_rd", mem_rd, e_rd);
      chk("mem_wr", mem_wr, e_wr);
      if (m_busy) chk("mem_address_clr", mem_address, m_idx);
      else if (e_if_g && e_rd) chk("mem_address_if", mem_address, if_addr);
      else if (e_d_g && (e_rd || e_wr)) chk("mem_address_d", mem_address, d_addr);
      if (e_wr) chk("mem_data", mem_data, d_wdata);
      chk("if_rvalid", if_rvalid, p_if_v);
      chk("if_rdata", if_rdata, h_if);
      chk("d_rvalid", d_rvalid, p_d_v);
      chk("d_rdata", d_rdata, h_d);
      chk("d_err", d_err, p_d_err);
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      if (!ref_seeded) begin
        for (int i = 0; i < 256; i++) ref_mem[i] <= seed_word(i);
        ref_seeded <= 1'b1;
      end
      m_busy <= 1'b0; m_idx <= 0; m_losses <= 0; m_last_d <= 1'b0;
      p_if_v <= 1'b0; p_d_v <= 1'b0; p_d_err <= 1'b0; h_if <= '0; h_d <= '0;
    end else begin
      p_if_v <= e_if_g;
      if (e_if_g) h_if <= inr(if_addr) ? ref_mem[if_addr[7:0]] : '0;
      p_d_v <= e_d_g && !d_we;
      if (e_d_g && !d_we) h_d <= inr(d_addr) ? ref_mem[d_addr[7:0]] : '0;
      p_d_err <= e_d_g && !inr(d_addr);
      if (e_wr) ref_mem[d_addr[7:0]] <= d_wdata;
      if (e_if_g) m_losses <= 0;
      else if (e_d_g && if_req) m_losses <= m_losses + 1;
      if (e_if_g) m_last_d <= 1'b0;
      else if (e_d_g) m_last_d <= 1'b1;
      if (m_busy) begin
        ref_mem[m_idx] <= '0;
        if (m_idx == DEPTH - 1) begin
          m_busy <= 1'b0;
          m_idx  <= 0;
        end else begin
          m_idx <= m_idx + 1;
        end
      end else if (clr_req) begin
        m_busy <= 1'b1;
      end
    end
  end

  task automatic d_op(input logic we, input int unsigned addr, input logic [DW-1:0] data);
    int n;
    bit got;
    n = 0;
    got = 1'b0;
    d_req = 1'b1; d_we = we; d_addr = addr[AW-1:0]; d_wdata = data;
    while (!got && n < 600) begin
      @(negedge clk);
      if (d_gnt) got = 1'b1; else n++;
    end
    if (!got) chk("d_gnt_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    d_req = 1'b0;
  endtask

  task automatic if_op(input int unsigned addr);
    int n;
    bit got;
    n = 0;
    got = 1'b0;
    if_req = 1'b1; if_addr = addr[AW-1:0];
    while (!got && n < 600) begin
      @(negedge clk);
      if (if_gnt) got = 1'b1; else n++;
    end
    if (!got) chk("if_gnt_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    if_req = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_flags"}, {if_gnt, if_rvalid, d_gnt, d_rvalid, d_err, clr_busy, mem_wr, mem_rd, mem_rst}, 64'd0);
    chk({tag, "_rdata"}, {if_rdata, d_rdata}, 64'd0);
    chk({tag, "_maddr"}, mem_address, 64'd0);
    chk({tag, "_mdata"}, mem_data, 64'd0);
  endtask

  function automatic logic [AW-1:0] rand_addr();
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r < 5) return AW'($urandom_range(0, 7));
    else if (r < 9) return AW'($urandom_range(0, 255));
    else return AW'($urandom_range(256, 1000));
  endfunction

  initial begin
    int  if_cnt, first_if, busy_n, mrst_n, first_k, k;
    bit  ig, dg, got, fd, found;

    @(posedge clk); #1;
    chk_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Store then load of the same word.
    d_op(1'b1, 5, 32'h1234_5678);
    chk("store_no_rvalid", d_rvalid, 1'b0);
    d_op(1'b0, 5, '0);
    chk("load5_rvalid", d_rvalid, 1'b1);
    chk("load5_rdata", d_rdata, 32'h1234_5678);

    // Continuous contention, both ports reading.
    if_cnt = 0; first_if = -1;
    if_req = 1'b1; if_addr = 28'd10; d_req = 1'b1; d_we = 1'b0; d_addr = 28'd20;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk); ig = if_gnt; dg = d_gnt;
      if (ig) begin
        if_cnt++;
        if (first_if < 0) first_if = c;
      end
      @(posedge clk); #1;
      if (ig) if_addr = AW'($urandom_range(0, 255));
      if (dg) d_addr = AW'($urandom_range(0, 255));
    end
    if_req = 1'b0; d_req = 1'b0;
`ifdef MEM_ARB_RR_EN
    chk("contend_if_count", if_cnt, 10);
    chk("contend_first_if", first_if, 0);
`else
    chk("contend_if_count", if_cnt, 4);
    chk("contend_first_if", first_if, 4);
`endif

    // Fill, clear with both ports waiting.
    for (int i = 0; i < 256; i++) d_op(1'b1, i, 32'hFFFF_FFFF);
    clr_req = 1'b1; if_req = 1'b1; if_addr = 28'd8; d_req = 1'b1; d_we = 1'b0; d_addr = 28'd7;
    @(posedge clk); #1;
    clr_req = 1'b0;
    busy_n = 0; mrst_n = 0; first_k = -1; k = 0; got = 1'b0; fd = 1'b0;
    while (!got && k < 400) begin
      @(negedge clk);
      if (clr_busy) busy_n++;
      if (mem_rst) mrst_n++;
      if (if_gnt || d_gnt) begin
        got = 1'b1; first_k = k; fd = d_gnt;
      end
      k++;
      @(posedge clk); #1;
    end
    if (!got) chk("clr_grant_timeout", 64'd0, 64'd1);
    chk("clr_busy_cycles", busy_n, 256);
    chk("clr_mem_rst_cycles", mrst_n, 256);
    chk("clr_first_grant_cycle", first_k, 256);
`ifdef MEM_ARB_RR_EN
    chk("clr_first_grant_d", fd, 1'b0);
`else
    chk("clr_first_grant_d", fd, 1'b1);
`endif
    if (fd) begin
      d_req = 1'b0;
      chk("clr_d_rdata", d_rdata, 32'd0);
      if_op(8);
      chk("clr_if_rdata", if_rdata, 32'd0);
    end else begin
      if_req = 1'b0;
      chk("clr_if_rdata", if_rdata, 32'd0);
      d_op(1'b0, 7, '0);
      chk("clr_d_rdata", d_rdata, 32'd0);
    end
    d_op(1'b0, 255, '0);
    chk("clr_last_word", d_rdata, 32'd0);

    // Out-of-range accesses.
    d_op(1'b0, 300, '0);
    chk("oor_load_rvalid", d_rvalid, 1'b1);
    chk("oor_load_rdata", d_rdata, 32'd0);
    chk("oor_load_err", d_err, 1'b1);
    d_op(1'b1, 300, 32'hABCD_0123);
    chk("oor_store_err", d_err, 1'b1);
    chk("oor_store_rvalid", d_rvalid, 1'b0);
    if_op(300);
    chk("oor_if_rdata", if_rdata, 32'd0);
    chk("oor_if_err", d_err, 1'b0);

    // Reset in the middle of a sweep.
    for (int i = 0; i < 256; i++) d_op(1'b1, i, 32'hCAFE_0000 | i);
    clr_req = 1'b1;
    @(posedge clk); #1;
    clr_req = 1'b0;
    found = 1'b0; k = 0;
    while (!found && k < 400) begin
      @(negedge clk);
      if (mem_rst && mem_address == 28'd100) found = 1'b1; else k++;
    end
    if (!found) chk("midclr_timeout", 64'd0, 64'd1);
    #1 rst = 1'b1;
    #1 chk_zero("midclr_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    d_op(1'b0, 99, '0);
    chk("midclr_addr99", d_rdata, 32'd0);
    d_op(1'b0, 100, '0);
    chk("midclr_addr100", d_rdata, 32'hCAFE_0064);
    d_op(1'b0, 150, '0);
    chk("midclr_addr150", d_rdata, 32'hCAFE_0096);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk); ig = if_gnt; dg = d_gnt;
      @(posedge clk); #1;
      clr_req = 1'b0;
      if (!if_req || ig) begin
        if_req  = ($urandom_range(0, 99) < 60);
        if_addr = rand_addr();
      end
      if (!d_req || dg) begin
        d_req   = ($urandom_range(0, 99) < 70);
        d_we    = $urandom_range(0, 1) != 0;
        d_addr  = rand_addr();
        d_wdata = $urandom;
      end
      if ($urandom_range(0, 999) == 0) clr_req = 1'b1;
    end
    if_req = 1'b0; d_req = 1'b0; clr_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
